fixed_divider_q11: RTL and testbench



---
 rtl/fixed_divider_q11_pkg.sv | 24 ++
 rtl/fixed_divider_q11_round_sat.sv | 34 +++
 rtl/fixed_divider_q11.sv | 129 ++++++++++++
 tb/tb_fixed_divider_q11.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_divider_q11_pkg.sv
// Shared fixed-point definitions for the accelerator datapath (16Q11 default).
package fixed_divider_q11_pkg;

  localparam int unsigned DWIDTH = 16;
  localparam int unsigned QWIDTH = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

  // Largest positive two's-complement value for a given width (0x7FFF for 16).
  function automatic logic [31:0] sat_pos(input int unsigned w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  // Most negative two's-complement value for a given width (0x8000 for 16).
  function automatic logic [31:0] sat_neg(input int unsigned w);
    return 32'h1 << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_divider_q11_round_sat.sv
// Raw magnitude quotient (one extra fractional bit) plus sign -> rounded,
// saturated signed result. Rounding is half away from zero on the magnitude.
module fixed_divider_q11_round_sat
  import fixed_divider_q11_pkg::*;
#(
  parameter int unsigned dwidth = DWIDTH,
  parameter int unsigned qw     = DWIDTH + QWIDTH + 1
) (
  input  logic [qw-1:0]     i_q,
  input  logic              i_sign,
  output logic [dwidth-1:0] o_dout
);

  localparam logic [dwidth-1:0] SAT_P   = dwidth'(sat_pos(dwidth));
  localparam logic [dwidth-1:0] SAT_N   = dwidth'(sat_neg(dwidth));
  localparam logic [qw-1:0]     MAG_POS = {{(qw-dwidth+1){1'b0}}, {(dwidth-1){1'b1}}};
  localparam logic [qw-1:0]     MAG_NEG = MAG_POS + {{(qw-1){1'b0}}, 1'b1};

  logic [qw-1:0] w_mag;

  // Drop the guard bit, add it back as the rounding increment, then clamp.
  always_comb begin
    w_mag  = (i_q >> 1) + {{(qw-1){1'b0}}, i_q[0]};
    o_dout = '0;
    if (w_mag == '0) begin
      o_dout = '0;
    end else if (!i_sign) begin
      o_dout = (w_mag > MAG_POS) ? SAT_P : w_mag[dwidth-1:0];
    end else begin
      o_dout = (w_mag > MAG_NEG) ? SAT_N : -w_mag[dwidth-1:0];
    end
  end

endmodule

// File: rtl/fixed_divider_q11.sv
// Sequential signed fixed-point divider, dout = din / win in Q(qwidth).
// Restoring division on magnitudes, one quotient bit per cycle, then a
// single rounding/saturation cycle. Valid/ready on both sides.
module fixed_divider_q11
  import fixed_divider_q11_pkg::*;
#(
  parameter int unsigned dwidth = DWIDTH,
  parameter int unsigned qwidth = QWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [dwidth-1:0] din,
  input  logic [dwidth-1:0] win,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dwidth-1:0] dout,
  output logic              div_zero
);

  localparam int unsigned N  = dwidth + qwidth + 1;
  localparam int unsigned CW = $clog2(N);
  localparam logic [dwidth-1:0] SAT_P = dwidth'(sat_pos(dwidth));
  localparam logic [dwidth-1:0] SAT_N = dwidth'(sat_neg(dwidth));

  div_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_num;
  logic [N-1:0]      r_quo;
  logic [dwidth:0]   r_rem;
  logic [dwidth-1:0] r_div;
  logic              r_sign;
  logic [dwidth-1:0] r_dout;
  logic              r_div_zero;
  logic              r_out_valid;

  logic [dwidth-1:0] w_din_abs;
  logic [dwidth-1:0] w_win_abs;
  logic [dwidth:0]   w_rem_sh;
  logic [dwidth:0]   w_sub;
  logic              w_ge;
  logic [dwidth-1:0] w_rs_dout;

  // Operand magnitudes (|-2^(dwidth-1)| still fits as unsigned) and the
  // trial subtraction for the current quotient bit.
  always_comb begin
    w_din_abs = din[dwidth-1] ? -din : din;
    w_win_abs = win[dwidth-1] ? -win : win;
    w_rem_sh  = {r_rem[dwidth-1:0], r_num[N-1]};
    w_sub     = w_rem_sh - {1'b0, r_div};
    w_ge      = (w_rem_sh >= {1'b0, r_div});
  end

  fixed_divider_q11_round_sat #(
    .dwidth (dwidth),
    .qw     (N)
  ) u_round_sat (
    .i_q    (r_quo),
    .i_sign (r_sign),
    .o_dout (w_rs_dout)
  );

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_sign      <= 1'b0;
      r_dout      <= '0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= din[dwidth-1] ^ win[dwidth-1];
            r_div  <= w_win_abs;
            r_num  <= {w_din_abs, {(qwidth+1){1'b0}}};
            r_quo  <= '0;
            r_rem  <= '0;
            r_cnt  <= CW'(N - 1);
            if (win == '0) begin
              r_dout      <= din[dwidth-1] ? SAT_N : SAT_P;
              r_div_zero  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub : w_rem_sh;
          r_quo <= {r_quo[N-2:0], w_ge};
          r_num <= {r_num[N-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_state <= S_ROUND;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_ROUND: begin
          r_dout      <= w_rs_dout;
          r_div_zero  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_fixed_divider_q11.sv
// Directed and random checks of fixed_divider_q11 with a result scoreboard.
module tb_fixed_divider_q11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [15:0] win;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  logic [16:0] sbq[$];

  always #5 clk = ~clk;

  fixed_divider_q11 #(
    .dwidth (16),
    .qwidth (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .win       (win),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact rational quotient, rounded half away from zero, clamped.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    longint sa, sd, num, q, r;
    bit     neg;
    if (b == 16'h0) return {1'b1, (a[15] ? 16'h8000 : 16'h7FFF)};
    sa  = longint'($signed(a));
    sd  = longint'($signed(b));
    neg = (sa < 0) != (sd < 0);
    if (sa < 0) sa = -sa;
    if (sd < 0) sd = -sd;
    num = sa * 2048;
    q   = num / sd;
    r   = num % sd;
    if (2 * r >= sd) q++;
    if (q == 0) return 17'h0;
    if (!neg) return {1'b0, (q > 32767 ? 16'h7FFF : q[15:0])};
    return {1'b0, (q > 32768 ? 16'h8000 : 16'(-q))};
  endfunction

  // Waits (bounded) for out_valid, counting cycles from the handshake cycle.
  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic compare_pop(input string tag);
    logic [16:0] e;
    if (sbq.size() == 0) begin
      check({tag, "/sb_empty"}, 32'(sbq.size()), 1);
      return;
    end
    e = sbq.pop_front();
    check({tag, "/dout"}, 32'(dout), 32'(e[15:0]));
    check({tag, "/div_zero"}, 32'(div_zero), 32'(e[16]));
  endtask

  // Full transaction from IDLE; caller is positioned just after a negedge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] exp, input string tag);
    int lat;
    sbq.push_back(exp);
    din      = a;
    win      = b;
    in_valid = 1'b1;
    check({tag, "/in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    wait_out(lat);
    check({tag, "/latency"}, lat, exp[16] ? 1 : 30);
    check({tag, "/out_valid"}, 32'(out_valid), 1);
    compare_pop(tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/post_ov"}, 32'(out_valid), 0);
    check({tag, "/post_ir"}, 32'(in_ready), 1);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra, rb;
    logic [16:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; win = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset/in_ready", 32'(in_ready), 1);
    check("reset/out_valid", 32'(out_valid), 0);
    check("reset/dout", 32'(dout), 0);
    check("reset/div_zero", 32'(div_zero), 0);

    run_op(16'h1800, 16'h1000, 17'h00C00, "3/2");
    run_op(16'hE800, 16'h1000, 17'h0F400, "-3/2");
    run_op(16'h0001, 16'h1000, 17'h00001, "tie_pos");
    run_op(16'hFFFF, 16'h1000, 17'h0FFFF, "tie_neg");
    run_op(16'h7FFF, 16'h0001, 17'h07FFF, "sat_pos");
    run_op(16'h8000, 16'h0001, 17'h08000, "sat_neg");
    run_op(16'h8000, 16'hF800, 17'h07FFF, "min_by_m1");
    run_op(16'h0800, 16'h1800, 17'h002AB, "third");
    run_op(16'h0800, 16'h0000, 17'h17FFF, "dz_pos");
    run_op(16'hF800, 16'h0000, 17'h18000, "dz_neg");
    run_op(16'h0000, 16'h0000, 17'h17FFF, "dz_zero");

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = (i == 3) ? 16'h0000 : 16'($urandom);
      run_op(ra, rb, model(ra, rb), "rand");
    end

    // Backpressure: result must hold while out_ready stays low.
    e = model(16'h1800, 16'h1000);
    sbq.push_back(e);
    din = 16'h1800; win = 16'h1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    wait_out(lat);
    check("bp/latency", lat, 30);
    for (int i = 0; i < 10; i++) begin
      din = 16'($urandom); win = 16'($urandom); in_valid = i[0];
      @(negedge clk);
      check("bp/dout_hold", 32'(dout), 32'(e[15:0]));
      check("bp/out_valid", 32'(out_valid), 1);
      check("bp/in_ready", 32'(in_ready), 0);
    end
    compare_pop("bp");
    sbq.push_back(17'h00800);
    din = 16'h0800; win = 16'h0800; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp/release_ir", 32'(in_ready), 1);
    check("bp/release_ov", 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp/reaccept", 32'(in_ready), 0);
    lat = 1;
    wait_out(lat);
    check("bp2/latency", lat, 30);
    compare_pop("bp2");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of CALC discards the operation.
    sbq.push_back(model(16'h1800, 16'h1000));
    din = 16'h1800; win = 16'h1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    check("midrst/in_ready", 32'(in_ready), 1);
    check("midrst/out_valid", 32'(out_valid), 0);
    check("midrst/dout", 32'(dout), 0);
    repeat (35) @(negedge clk);
    check("midrst/no_stale", 32'(out_valid), 0);
    run_op(16'h0800, 16'h0800, 17'h00800, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
